dmem_bus_bridge: RTL and testbench

Memory-stage bus bridge between the pipeline MEM stage and a valid/ready data bus with variable latency. It sits directly downstream of the datapath's MEM-stage outputs (ALUResultM, WriteDataM, MemWriteM, byteEnable). It returns the raw load word to the load extender and raises MemStall to the hazard unit while a transaction is outstanding. It also aligns store data onto byte lanes and flags bus errors and timeouts.

---
 rtl/dmem_bridge_pkg.sv | 19 +
 rtl/store_lane_align.sv | 13 +
 rtl/dmem_bus_bridge.sv | 131 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the MEM-stage data bus bridge.
// Holds the FSM state encoding and the store byte-lane shifter.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 256;

  // Right-justified store data moves up to the byte lane picked by the low address bits.
  function automatic logic [31:0] lane_shift(input logic [1:0] addr, input logic [31:0] data);
    return data << {addr, 3'b000};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store-data aligner: places right-justified store data
// onto the byte lanes selected by the low two address bits.
module store_lane_align
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] wdata_o
);

  assign wdata_o = lane_shift(addr_lo_i, wdata_i);

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage bridge onto a valid/ready data bus with variable latency.
// Stalls the pipeline while a transaction is outstanding and flags errors/timeouts.
module dmem_bus_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] RD_data,
  output logic        MemStall,
  output logic        mem_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rerr
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [3:0]        strb_q;
  logic              write_q, fault_q;
  logic [31:0]       alignedData;
  logic              inFlight, beat, atLimit, timedOut, startReq;

  store_lane_align u_align (
    .wdata_i   (WriteDataM),
    .addr_lo_i (ALUResultM[1:0]),
    .wdata_o   (alignedData)
  );

  // A beat in REQ only counts when the same cycle also carries the accept (zero-wait bus).
  assign inFlight = (state_q == REQ) || (state_q == RESP);
  assign beat     = ((state_q == REQ) && bus_ready && bus_rvalid) ||
                    ((state_q == RESP) && bus_rvalid);
  assign atLimit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign timedOut = inFlight && !beat && atLimit;
  assign startReq = (state_q == IDLE) && MemReqM;
  assign cnt_d    = inFlight ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (MemReqM) begin
          state_d = (MemWriteM && (byteEnable == 4'b0000)) ? DONE : REQ;
        end
      end
      REQ: begin
        if (beat || timedOut) begin
          state_d = DONE;
        end else if (bus_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (beat || timedOut) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_valid = (state_q == REQ);
    MemStall  = MemReqM && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (startReq) begin
        addr_q  <= {ALUResultM[31:2], 2'b00};
        write_q <= MemWriteM;
        strb_q  <= MemWriteM ? byteEnable : 4'b0000;
        wdata_q <= alignedData;
      end
      if (beat) begin
        if (!write_q) begin
          rdata_q <= bus_rdata;
        end
        if (bus_rerr) begin
          fault_q <= 1'b1;
        end
      end
      // Abandoned transactions return zero so a stale word never reaches the load extender.
      if (timedOut) begin
        rdata_q <= '0;
        fault_q <= 1'b1;
      end
    end
  end

  assign bus_addr  = addr_q;
  assign bus_write = write_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = strb_q;
  assign RD_data   = rdata_q;
  assign mem_fault = fault_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed self-checking bench for dmem_bus_bridge, built with TIMEOUT=8.
// A small bus responder answers each request; expected values are hand-computed.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        clr;
  logic        MemReqM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  byteEnable;
  logic [31:0] RD_data;
  logic        MemStall, mem_fault;
  logic        bus_valid, bus_ready, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid, bus_rerr;
  logic [31:0] bus_rdata;

  int checkCount = 0;
  int failCount  = 0;
  int stallCycles, validCycles, payloadBad;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .byteEnable (byteEnable),
    .RD_data    (RD_data),
    .MemStall   (MemStall),
    .mem_fault  (mem_fault),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_rerr   (bus_rerr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic clearBus();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rerr   = 1'b0;
    bus_rdata  = 32'h0;
  endtask

  task automatic idleCycles(input int n);
    MemReqM = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issues one request at the next negedge and plays the bus: ready after waitCycles
  // REQ cycles, rvalid either with ready (zeroWait) or one cycle later. Returns in DONE.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int waitCycles, input logic zeroWait,
                               input logic [31:0] rdata, input logic rerr, input logic [31:0] expAddr,
                               input logic [31:0] expWdata, input logic [3:0] expStrb);
    int   reqSeen;
    logic accepted, responded, finished;
    reqSeen = 0; accepted = 1'b0; responded = 1'b0; finished = 1'b0;
    stallCycles = 0; validCycles = 0; payloadBad = 0;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = isWrite; ALUResultM = addr; WriteDataM = wdata; byteEnable = be;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      #1;
      if (!MemStall) begin
        finished = 1'b1;
      end else begin
        stallCycles++;
        clearBus();
        if (bus_valid) begin
          validCycles++;
          if (bus_addr !== expAddr || bus_wdata !== expWdata || bus_wstrb !== expStrb || bus_write !== isWrite)
            payloadBad++;
          if (reqSeen >= waitCycles) begin
            bus_ready = 1'b1;
            accepted  = 1'b1;
            if (zeroWait) begin
              bus_rvalid = 1'b1; bus_rdata = rdata; bus_rerr = rerr; responded = 1'b1;
            end
          end
          reqSeen++;
        end else if (accepted && !responded) begin
          bus_rvalid = 1'b1; bus_rdata = rdata; bus_rerr = rerr; responded = 1'b1;
        end
        @(negedge clk);
      end
    end
    clearBus();
    checkOutput("txnCompleted", 32'(finished), 32'd1);
  endtask

  initial begin
    clr = 1'b1;
    MemReqM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0; byteEnable = 4'h0;
    clearBus();
    #12;
    checkOutput("rstValid", 32'(bus_valid), 32'd0);
    checkOutput("rstAddr", bus_addr, 32'h0);
    checkOutput("rstWdata", bus_wdata, 32'h0);
    checkOutput("rstWstrb", 32'(bus_wstrb), 32'h0);
    checkOutput("rstWrite", 32'(bus_write), 32'd0);
    checkOutput("rstRdData", RD_data, 32'h0);
    checkOutput("rstFault", 32'(mem_fault), 32'd0);
    checkOutput("rstStall", 32'(MemStall), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    idleCycles(1);

    // lw with one-cycle accept and next-cycle response
    applyStimulus(1'b0, 32'h0000_1008, 32'h0, 4'b1111, 0, 1'b0, 32'hDEAD_BEEF, 1'b0,
                  32'h0000_1008, 32'h0, 4'b0000);
    checkOutput("lwStall", 32'(stallCycles), 32'd3);
    checkOutput("lwPayload", 32'(payloadBad), 32'd0);
    checkOutput("lwRdData", RD_data, 32'hDEAD_BEEF);
    checkOutput("lwFault", 32'(mem_fault), 32'd0);
    checkOutput("lwAddr", bus_addr, 32'h0000_1008);
    checkOutput("lwWstrb", 32'(bus_wstrb), 32'h0);

    // sb at the top byte lane, zero-wait bus
    idleCycles(1);
    applyStimulus(1'b1, 32'h0000_2003, 32'h0000_00A5, 4'b1000, 0, 1'b1, 32'h0, 1'b0,
                  32'h0000_2000, 32'hA500_0000, 4'b1000);
    checkOutput("sbStall", 32'(stallCycles), 32'd2);
    checkOutput("sbPayload", 32'(payloadBad), 32'd0);
    checkOutput("sbWdata", bus_wdata, 32'hA500_0000);
    checkOutput("sbWstrb", 32'(bus_wstrb), 32'h8);
    checkOutput("sbWrite", 32'(bus_write), 32'd1);
    checkOutput("sbKeepsRdData", RD_data, 32'hDEAD_BEEF);

    // sh on the upper half with ready held low for four cycles
    idleCycles(2);
    applyStimulus(1'b1, 32'h0000_3002, 32'h0000_1234, 4'b1100, 4, 1'b0, 32'h0, 1'b0,
                  32'h0000_3000, 32'h1234_0000, 4'b1100);
    checkOutput("shStall", 32'(stallCycles), 32'd7);
    checkOutput("shValidCycles", 32'(validCycles), 32'd5);
    checkOutput("shPayloadStable", 32'(payloadBad), 32'd0);
    checkOutput("shWdata", bus_wdata, 32'h1234_0000);

    // error response, then a back-to-back good load; the fault must stick
    idleCycles(1);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'b1111, 0, 1'b0, 32'h0000_0055, 1'b1,
                  32'h0000_0040, 32'h0, 4'b0000);
    checkOutput("errRdData", RD_data, 32'h0000_0055);
    checkOutput("errFault", 32'(mem_fault), 32'd1);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 4'b1111, 0, 1'b0, 32'h1111_1111, 1'b0,
                  32'h0000_0044, 32'h0, 4'b0000);
    checkOutput("b2bStall", 32'(stallCycles), 32'd3);
    checkOutput("b2bRdData", RD_data, 32'h1111_1111);
    checkOutput("faultSticky", 32'(mem_fault), 32'd1);

    // store with no enabled lanes skips the bus entirely
    idleCycles(1);
    applyStimulus(1'b1, 32'h0000_0050, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0, 32'h0, 1'b0,
                  32'h0, 32'h0, 4'b0000);
    checkOutput("noLaneStall", 32'(stallCycles), 32'd1);
    checkOutput("noLaneValid", 32'(validCycles), 32'd0);

    // async reset while waiting in RESP, then a stray late response
    idleCycles(1);
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h0000_0080; byteEnable = 4'b1111;
    @(negedge clk);
    #1 bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #3 clr = 1'b1;
    #1;
    checkOutput("rstRespValid", 32'(bus_valid), 32'd0);
    checkOutput("rstRespRdData", RD_data, 32'h0);
    checkOutput("rstRespFault", 32'(mem_fault), 32'd0);
    checkOutput("rstRespAddr", bus_addr, 32'h0);
    MemReqM = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h0000_0077;
    @(negedge clk);
    clearBus();
    #1;
    checkOutput("lateRvalidRdData", RD_data, 32'h0);
    checkOutput("lateRvalidStall", 32'(MemStall), 32'd0);

    // async reset while a store sits in REQ drops bus_valid before the next edge
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h0000_0010; WriteDataM = 32'h0102_0304;
    byteEnable = 4'b1111;
    @(negedge clk);
    #1;
    checkOutput("reqValid", 32'(bus_valid), 32'd1);
    #2 clr = 1'b1;
    #1;
    checkOutput("rstReqValid", 32'(bus_valid), 32'd0);
    checkOutput("rstReqWstrb", 32'(bus_wstrb), 32'h0);
    MemReqM = 1'b0;
    @(negedge clk);
    clr = 1'b0;

    // the next load after reset completes normally
    applyStimulus(1'b0, 32'h0000_00C0, 32'h0, 4'b1111, 0, 1'b0, 32'hCAFE_F00D, 1'b0,
                  32'h0000_00C0, 32'h0, 4'b0000);
    checkOutput("postRstStall", 32'(stallCycles), 32'd3);
    checkOutput("postRstRdData", RD_data, 32'hCAFE_F00D);
    checkOutput("postRstFault", 32'(mem_fault), 32'd0);

    // timeout: ready never comes, eight REQ cycles then DONE
    idleCycles(1);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'b1111, 1000, 1'b0, 32'h0, 1'b0,
                  32'h0000_0100, 32'h0, 4'b0000);
    checkOutput("toValidCycles", 32'(validCycles), 32'd8);
    checkOutput("toStall", 32'(stallCycles), 32'd9);
    checkOutput("toRdData", RD_data, 32'h0);
    checkOutput("toFault", 32'(mem_fault), 32'd1);
    checkOutput("toValidDone", 32'(bus_valid), 32'd0);
    MemReqM = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h0000_0099;
    @(negedge clk);
    clearBus();
    #1;
    checkOutput("toStrayRdData", RD_data, 32'h0);
    checkOutput("toStrayValid", 32'(bus_valid), 32'd0);
    checkOutput("toStrayFault", 32'(mem_fault), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
